// File: rtl/misr_pkg.sv
// rtl/misr_pkg.sv - shared types and constants for the MISR signature analyzer
// Contents: run-control state enum, default feedback polynomials for common widths.
package misr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Feedback taps, bit i set feeds s[WIDTH-1] into stage i (x^WIDTH term implied)
    localparam logic [7:0]  POLY_W8  = 8'h1D;          // x^8+x^4+x^3+x^2+1
    localparam logic [9:0]  POLY_W10 = 10'h009;        // x^10+x^3+1
    localparam logic [15:0] POLY_W16 = 16'h1021;       // x^16+x^12+x^5+1
    localparam logic [31:0] POLY_W32 = 32'h04C1_1DB7;  // CRC-32 polynomial

endpackage

// File: rtl/misr_core.sv
// rtl/misr_core.sv - registered MISR compaction stage
// Ports:
//   CLK  in           clock, rising edge
//   RST  in           asynchronous reset, active-high, loads SEED
//   load in           reload SEED (wins over en)
//   en   in           perform one compaction step with din
//   din  in  [NIN]    parallel response bits, xored into stages 0..NIN-1
//   sig  out [WIDTH]  signature register
module misr_core
    import misr_pkg::*;
#(
    parameter int               WIDTH = 10,
    parameter int               NIN   = 3,
    parameter logic [WIDTH-1:0] POLY  = POLY_W10,
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             en,
    input  logic [NIN-1:0]   din,
    output logic [WIDTH-1:0] sig
);

    logic             fb;
    logic [WIDTH-1:0] din_ext;
    logic [WIDTH-1:0] sig_next;

    always_comb begin
        din_ext          = '0;
        din_ext[NIN-1:0] = din;
        fb               = sig[WIDTH-1];
        sig_next         = {sig[WIDTH-2:0], 1'b0} ^ (POLY & {WIDTH{fb}}) ^ din_ext;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sig <= SEED;
        end else if (load) begin
            sig <= SEED;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/misr_sig_analyzer.sv
// rtl/misr_sig_analyzer.sv - MISR with run control and golden-signature compare
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   start               begin a run (IDLE only); samples cycles and golden
//   abort               end a run in RUN/DONE without a done pulse
//   cycles  [CNT_W]     number of valid compaction cycles
//   golden  [WIDTH]     expected signature
//   din     [NIN]       response bits, compacted when din_valid in RUN
//   din_valid           din is compacted this cycle
//   busy                high in RUN and DONE
//   done                one-cycle pulse when pass/sig are final
//   pass                registered compare result, held until next start
//   sig     [WIDTH]     current signature
module misr_sig_analyzer
    import misr_pkg::*;
#(
    parameter int               WIDTH = 10,
    parameter int               NIN   = 3,
    parameter logic [WIDTH-1:0] POLY  = POLY_W10,
    parameter logic [WIDTH-1:0] SEED  = '0,
    parameter int               CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] cycles,
    input  logic [WIDTH-1:0] golden,
    input  logic [NIN-1:0]   din,
    input  logic             din_valid,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] sig
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [WIDTH-1:0] golden_q, golden_d;
    logic             pass_d, done_d, busy_d;
    logic             load, en;

    // Look-ahead of the core's next signature so pass is valid on entry to DONE
    logic [WIDTH-1:0] din_ext;
    logic [WIDTH-1:0] sig_step;

    always_comb begin
        din_ext          = '0;
        din_ext[NIN-1:0] = din;
        sig_step         = {sig[WIDTH-2:0], 1'b0} ^ (POLY & {WIDTH{sig[WIDTH-1]}}) ^ din_ext;
    end

    misr_core #(
        .WIDTH (WIDTH),
        .NIN   (NIN),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_core (
        .CLK  (CLK),
        .RST  (RST),
        .load (load),
        .en   (en),
        .din  (din),
        .sig  (sig)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        golden_d = golden_q;
        pass_d   = pass;
        done_d   = 1'b0;
        load     = 1'b0;
        en       = 1'b0;

        unique case (state_q)
            IDLE: begin
                // abort outranks start even though it has nothing to stop here
                if (start && !abort) begin
                    load     = 1'b1;
                    golden_d = golden;
                    cycles_d = cycles;
                    cnt_d    = '0;
                    pass_d   = 1'b0;
                    if (cycles == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = (SEED == golden);
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                end else if (din_valid) begin
                    en    = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    // cycles_q is non-zero in RUN, so cycles_q-1 cannot underflow
                    if (cnt_q == cycles_q - CNT_W'(1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = (sig_step == golden_q);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (abort) begin
                    pass_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cycles_q <= '0;
            golden_q <= '0;
            pass     <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
            golden_q <= golden_d;
            pass     <= pass_d;
            done     <= done_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_misr_sig_analyzer.sv
// tb/tb_misr_sig_analyzer.sv - scoreboard bench for misr_sig_analyzer
module tb_misr_sig_analyzer;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // small instance: WIDTH=4, NIN=1, POLY=4'b0011, SEED=0, CNT_W=4
    logic       s_start, s_abort, s_valid, s_busy, s_done, s_pass;
    logic [3:0] s_cycles, s_golden, s_sig;
    logic [0:0] s_din;
    // default-parameter instance
    logic        d_start, d_abort, d_valid, d_busy, d_done, d_pass;
    logic [15:0] d_cycles;
    logic [9:0]  d_golden, d_sig;
    logic [2:0]  d_din;

    misr_sig_analyzer #(
        .WIDTH (4), .NIN (1), .POLY (4'b0011), .SEED (4'h0), .CNT_W (4)
    ) u_small (
        .CLK (CLK), .RST (RST), .start (s_start), .abort (s_abort),
        .cycles (s_cycles), .golden (s_golden), .din (s_din), .din_valid (s_valid),
        .busy (s_busy), .done (s_done), .pass (s_pass), .sig (s_sig)
    );

    misr_sig_analyzer u_def (
        .CLK (CLK), .RST (RST), .start (d_start), .abort (d_abort),
        .cycles (d_cycles), .golden (d_golden), .din (d_din), .din_valid (d_valid),
        .busy (d_busy), .done (d_done), .pass (d_pass), .sig (d_sig)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] sig;
        logic        pass;
        int          cyc;
    } exp_t;

    exp_t        q_s[$];
    exp_t        q_d[$];
    logic [31:0] stim[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Reference: signature times x, plus input, reduced modulo x^w + poly
    function automatic logic [31:0] mstep(input logic [31:0] s, input logic [31:0] d,
                                          input int w, input logic [31:0] poly);
        logic [32:0] t;
        t = ({1'b0, s} << 1) ^ {1'b0, d};
        if (t[w]) t = t ^ ((33'd1 << w) | {1'b0, poly});
        return t[31:0];
    endfunction

    function automatic int width_of(input int which);
        return (which == 0) ? 4 : 10;
    endfunction

    function automatic logic [31:0] poly_of(input int which);
        return (which == 0) ? 32'h3 : 32'h009;
    endfunction

    function automatic logic [31:0] get_sig(input int which);
        return (which == 0) ? 32'(s_sig) : 32'(d_sig);
    endfunction

    function automatic logic [31:0] get_busy(input int which);
        return (which == 0) ? 32'(s_busy) : 32'(d_busy);
    endfunction

    function automatic logic [31:0] get_pass(input int which);
        return (which == 0) ? 32'(s_pass) : 32'(d_pass);
    endfunction

    task automatic set_in(input int which, input logic st, input logic ab, input int cy,
                          input logic [31:0] go, input logic [31:0] di, input logic va);
        logic [31:0] cy32;
        cy32 = 32'(cy);
        if (which == 0) begin
            s_start = st; s_abort = ab; s_cycles = cy32[3:0]; s_golden = go[3:0];
            s_din = di[0:0]; s_valid = va;
        end else begin
            d_start = st; d_abort = ab; d_cycles = cy32[15:0]; d_golden = go[9:0];
            d_din = di[2:0]; d_valid = va;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every done pulse must match the oldest expected result for that instance
    always @(negedge CLK) begin
        exp_t e;
        if (!RST) begin
            if (s_done) begin
                if (q_s.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL s_unexpected_done: got done=1 want done=0 (cycle %0d)", cyc);
                end else begin
                    e = q_s.pop_front();
                    chk("s_sig_at_done", 32'(s_sig), e.sig);
                    chk("s_pass_at_done", 32'(s_pass), 32'(e.pass));
                    chk("s_done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("s_busy_at_done", 32'(s_busy), 32'd1);
                end
            end
            if (d_done) begin
                if (q_d.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL d_unexpected_done: got done=1 want done=0 (cycle %0d)", cyc);
                end else begin
                    e = q_d.pop_front();
                    chk("d_sig_at_done", 32'(d_sig), e.sig);
                    chk("d_pass_at_done", 32'(d_pass), 32'(e.pass));
                    chk("d_done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("d_busy_at_done", 32'(d_busy), 32'd1);
                end
            end
        end
    end

    // One run over stim[0..n-1]; din_valid low for st_len cycles from T+st_from;
    // a stray start (cycles=1, golden=0) is pulsed at T+poke_at when poke_at > 0.
    task automatic run(input int which, input int n, input logic [31:0] gold,
                       input int st_from, input int st_len, input int poke_at);
        int          w, t0, idx, rel;
        logic [31:0] poly, s, acc;
        logic        v, pk;
        exp_t        e;
        w    = width_of(which);
        poly = poly_of(which);
        s    = 0;
        for (int i = 0; i < n; i++) s = mstep(s, stim[i], w, poly);
        t0    = cyc;
        e.sig = s;
        e.pass = (s == gold);
        e.cyc = t0 + 1 + n + st_len;
        if (which == 0) q_s.push_back(e); else q_d.push_back(e);
        set_in(which, 1'b1, 1'b0, n, gold, 0, 1'b0);
        tick();
        idx = 0;
        acc = 0;
        while (idx < n) begin
            rel = cyc - t0;
            v   = !(rel >= st_from && rel < st_from + st_len);
            pk  = (rel == poke_at);
            set_in(which, pk, 1'b0, pk ? 1 : n, pk ? 32'h0 : gold, v ? stim[idx] : 32'h0, v);
            tick();
            if (v) begin
                acc = mstep(acc, stim[idx], w, poly);
                idx++;
                chk("sig_step", get_sig(which), acc);
            end
        end
        set_in(which, 1'b0, 1'b0, n, gold, 0, 1'b0);
        tick();
        chk("busy_after_done", get_busy(which), 32'd0);
        chk("pass_hold", get_pass(which), 32'(e.pass));
        chk("sig_hold", get_sig(which), s);
        tick();
    endtask

    task automatic fill(input int n, input int which, input bit ones);
        stim.delete();
        for (int i = 0; i < n; i++) begin
            if (ones) stim.push_back(32'h1);
            else stim.push_back((which == 0) ? 32'($urandom_range(0, 1)) : 32'($urandom_range(0, 7)));
        end
    endtask

    function automatic logic [31:0] model_sig(input int which, input int n);
        logic [31:0] s;
        s = 0;
        for (int i = 0; i < n; i++) s = mstep(s, stim[i], width_of(which), poly_of(which));
        return s;
    endfunction

    initial begin
        logic [31:0] g;
        int          n;
        int          t0;
        set_in(0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        set_in(1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        tick();
        chk("reset_s_sig", 32'(s_sig), 32'h0);
        chk("reset_s_busy", 32'(s_busy), 32'd0);
        chk("reset_s_done", 32'(s_done), 32'd0);
        chk("reset_s_pass", 32'(s_pass), 32'd0);
        chk("reset_d_sig", 32'(d_sig), 32'h0);
        chk("reset_d_busy", 32'(d_busy), 32'd0);

        // four-cycle run, ones: 1,3,7,F, pass
        fill(4, 0, 1'b1);
        run(0, 4, 32'hF, 0, 0, 0);
        chk("s1_sig_F", 32'(s_sig), 32'hF);
        chk("s1_pass", 32'(s_pass), 32'd1);

        // five-cycle run, ones: C, fail
        fill(5, 0, 1'b1);
        run(0, 5, 32'hF, 0, 0, 0);
        chk("s2_sig_C", 32'(s_sig), 32'hC);
        chk("s2_pass", 32'(s_pass), 32'd0);

        // stalled input at T+2, T+3
        fill(4, 0, 1'b1);
        run(0, 4, 32'hF, 2, 2, 0);
        chk("s3_sig_F", 32'(s_sig), 32'hF);

        // zero-length run
        stim.delete();
        run(0, 0, 32'h0, 0, 0, 0);
        chk("s4_pass", 32'(s_pass), 32'd1);

        // start pulsed during RUN is ignored
        fill(4, 0, 1'b1);
        run(0, 4, 32'hF, 0, 0, 2);
        chk("s6_start_ignored_pass", 32'(s_pass), 32'd1);

        // longest run for a 4-bit counter, no wrap
        fill(15, 0, 1'b0);
        g = model_sig(0, 15);
        run(0, 15, g, 0, 0, 0);

        // abort at T+2
        t0 = cyc;
        set_in(0, 1'b1, 1'b0, 4, 32'hF, 0, 1'b0);
        tick();
        set_in(0, 1'b0, 1'b0, 4, 32'hF, 1, 1'b1);
        tick();
        chk("abort_sig_before", 32'(s_sig), 32'h1);
        set_in(0, 1'b0, 1'b1, 4, 32'hF, 1, 1'b1);
        tick();
        chk("abort_cycle", 32'(cyc - t0), 32'd3);
        chk("abort_busy", 32'(s_busy), 32'd0);
        chk("abort_done", 32'(s_done), 32'd0);
        chk("abort_pass", 32'(s_pass), 32'd0);
        chk("abort_sig_hold", 32'(s_sig), 32'h1);
        set_in(0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        repeat (6) tick();

        // reset at T+3 of a fresh run
        set_in(0, 1'b1, 1'b0, 10, 32'h5, 0, 1'b0);
        tick();
        set_in(0, 1'b0, 1'b0, 10, 32'h5, 1, 1'b1);
        tick();
        tick();
        chk("rst_sig_before", 32'(s_sig), 32'h3);
        RST = 1'b1;
        #1;
        chk("rst_sig", 32'(s_sig), 32'h0);
        chk("rst_busy", 32'(s_busy), 32'd0);
        chk("rst_done", 32'(s_done), 32'd0);
        chk("rst_pass", 32'(s_pass), 32'd0);
        set_in(0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        tick();
        RST = 1'b0;
        repeat (14) tick();

        // default parameters, 1000 random vectors, matching and one-bit-off golden
        fill(1000, 1, 1'b0);
        g = model_sig(1, 1000);
        run(1, 1000, g, 0, 0, 0);
        chk("d_pass_match", 32'(d_pass), 32'd1);
        run(1, 1000, g ^ (32'h1 << $urandom_range(0, 9)), 0, 0, 0);
        chk("d_pass_flip", 32'(d_pass), 32'd0);

        // a few random stalled runs on the default instance
        for (int k = 0; k < 4; k++) begin
            n = $urandom_range(1, 40);
            fill(n, 1, 1'b0);
            g = (k[0]) ? model_sig(1, n) : 32'($urandom_range(0, 1023));
            run(1, n, g, $urandom_range(1, n), $urandom_range(1, 5), 0);
        end

        repeat (3) tick();
        chk("s_queue_drained", 32'(q_s.size()), 32'd0);
        chk("d_queue_drained", 32'(q_d.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/misr_sig_analyzer.md
# misr_sig_analyzer

Parametrised multiple-input signature register (MISR) with run control and golden-signature compare. It compacts NIN parallel response bits per valid cycle into a WIDTH-bit signature over a programmed number of cycles, then compares the result against a golden value and reports pass or fail. It sits at the output of the circuit under test in the BIST path and succeeds the fixed 10-bit, 3-input, free-running signature register.

## Interface
- WIDTH, 10: signature width, ≥ 2.
- NIN, 3: number of parallel response inputs, 1 ≤ NIN ≤ WIDTH.
- POLY, 10'h009: feedback taps. Bit i set means s[WIDTH-1] is fed back into stage i. Default is x^10+x^3+1.
- SEED, 0: signature value loaded on start.
- CNT_W, 16: width of the cycle counter.

Ports:
- CLK, in, 1: clock, rising edge.
- RST, in, 1: asynchronous reset, active-high.
- start, in, 1: one-cycle request to begin a run. Honoured only in IDLE.
- abort, in, 1: ends a run immediately and returns to IDLE. done is not asserted.
- cycles, in, CNT_W: number of valid compaction cycles. Sampled on start.
- golden, in, WIDTH: expected signature. Sampled on start.
- din, in, NIN: response bits to compact.
- din_valid, in, 1: din is compacted this cycle. Only meaningful in RUN.
- busy, out, 1: high in RUN and DONE.
- done, out, 1: one-cycle pulse when the result is available.
- pass, out, 1: registered compare result. Holds until the next start.
- sig, out, WIDTH: current signature register.

## Operation
- States are IDLE, RUN and DONE. All outputs are driven directly from registers.
- Reset values: state=IDLE, sig=SEED, pass=0, done=0, busy=0. Internal counter, golden_q and cycles_q are reset to 0.
- IDLE with start=1:
  - load sig=SEED, golden_q=golden, cnt=0, clear pass.
  - If cycles=0, go to DONE; otherwise go to RUN.
- Compaction step, performed in RUN when din_valid=1:
  - fb = sig[WIDTH-1].
  - new[i] = (i>0 ? sig[i-1] : 0) ^ (POLY[i] & fb) ^ (i<NIN ? din[i] : 0).
  - cnt increments.
- RUN with din_valid=0: sig and cnt hold, no timeout.
- RUN, at the compaction where cnt reaches cycles_q: go to DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - pass is registered on entry as (final sig == golden_q).
  - Next cycle returns to IDLE.
  - sig and pass hold in IDLE until the next start.
- abort=1 in RUN or DONE: go to IDLE next cycle, done is not pulsed, pass=0, sig holds.
- abort in IDLE has no effect. abort takes priority over compaction and over start.
- start while busy is ignored.
- RST asserted mid-run returns all registers to their reset values immediately, with no done pulse.

## Timing
- With start at cycle T and din_valid continuously high:
  - compactions occur at T+1 through T+cycles.
  - done and pass are valid at T+cycles+1.
  - busy falls at T+cycles+2.
- cycles=0: done at T+1, and pass compares SEED against golden.
- Each din_valid=0 cycle delays done by one cycle.
- The earliest back-to-back start is accepted in the cycle after DONE, i.e. in IDLE.
- cnt is CNT_W bits wide. cycles = 2^CNT_W − 1 must complete without wrap.

## Structure
- Shared package misr_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the default POLY constants for widths 8, 10, 16 and 32.
- One natural sub-module, misr_core: a purely registered compaction stage with parameters WIDTH, NIN, POLY and SEED, and ports CLK, RST, load, en, din, sig.
- The FSM, counter and compare live in the top level.

## Test plan
All scenarios except 5 use WIDTH=4, NIN=1, POLY=4'b0011, SEED=0.
1. Four-cycle run: cycles=4, din=1 continuously, golden=4'hF. Required: sig steps 1, 3, 7, F; done at T+5; pass=1.
2. Five-cycle run: same as scenario 1 with cycles=5 and golden=4'hF. Required: sig=4'hC, pass=0.
3. Stalled input: scenario 1 with din_valid dropped on cycles T+2 and T+3. Required: same signature; done at T+7.
4. Zero-length run: cycles=0, golden=0. Required: done at T+1, pass=1.
5. Default parameters, 1000 random din vectors: sig matches the software model; pass=1 when golden equals the model result and pass=0 when golden has one bit flipped.
6. Interruptions: abort at T+2 gives no done pulse and busy=0 at T+3. RST asserted at T+3 of a fresh run returns all outputs to their reset values immediately. start pulsed during RUN is ignored.
